// File: rtl/oam_dma.sv
//----------------------------------------------------------------------------
// Module   : oam_dma
// Purpose  : Sprite OAM DMA engine. Snoops CPU writes to TRIGGER_ADDR; on a
//            hit it halts the CPU, aligns to a get cycle, then copies 256
//            bytes from CPU page $XX00-$XXFF into OAMDATA by alternating bus
//            reads and writes. The top level muxes dma_addr/dma_rw/
//            dma_data_o onto the CPU bus while dma_active is high.
// Ports    : clk, rst (async, active-low), ce (CPU cycle enable)
//            cpu_addr/cpu_rw/cpu_data_o : snooped CPU bus signals
//            bus_data_i                 : bus read data, one clk after address
//            dma_active/cpu_halt        : bus ownership / CPU stall
//            dma_addr/dma_rw/dma_data_o : DMA bus-initiator signals
//            dma_done                   : one-clk pulse after the final write
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_o,
  input  logic [7:0]  bus_data_i,
  output logic        dma_active,
  output logic        cpu_halt,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_data_o,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  page_q, page_d;
  logic        rd_pending_q, rd_pending_d;
  logic [7:0]  data_latch_q, data_latch_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      idx_q        <= 8'h00;
      page_q       <= 8'h00;
      rd_pending_q <= 1'b0;
      data_latch_q <= 8'h00;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      page_q       <= page_d;
      rd_pending_q <= rd_pending_d;
      data_latch_q <= data_latch_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    page_d       = page_q;
    done_d       = 1'b0;
    // Read data is captured on the first clk after the read cycle ends,
    // independent of ce, so gated-ce systems still see the bus value that
    // belongs to the DMA read address.
    rd_pending_d = 1'b0;
    data_latch_d = rd_pending_q ? bus_data_i : data_latch_q;

    if (ce) begin
      phase_d = ~phase_q;
      unique case (state_q)
        S_IDLE: begin
          if (!cpu_rw && (cpu_addr == TRIGGER_ADDR)) begin
            page_d  = cpu_data_o;
            idx_d   = 8'h00;
            state_d = S_HALT;
          end
        end
        // The first read must land on a get cycle (phase 0 next), so a
        // halt on phase 0 needs one extra alignment cycle.
        S_HALT:  state_d = phase_q ? S_READ : S_ALIGN;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          rd_pending_d = 1'b1;
          state_d      = S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_halt   = (state_q != S_IDLE);
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_rw     = 1'b1;
    if (state_q == S_READ) begin
      dma_active = 1'b1;
      dma_addr   = {page_q, idx_q};
    end else if (state_q == S_WRITE) begin
      dma_active = 1'b1;
      dma_addr   = OAMDATA_ADDR;
      dma_rw     = 1'b0;
    end
  end

  // Forward live bus data during the clk the read is still pending so the
  // write cycle carries valid data even when ce is high every clk.
  assign dma_data_o = rd_pending_q ? bus_data_i : data_latch_q;
  assign dma_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
//----------------------------------------------------------------------------
// Module   : tb_oam_dma
// Purpose  : Self-checking bench for oam_dma with a 64 KiB bus memory model
//            and read-address / write-data scoreboards.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_oam_dma;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_data_o;
  logic [7:0]  bus_data_i;
  logic        dma_active;
  logic        cpu_halt;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_data_o;
  logic        dma_done;

  oam_dma u_dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .cpu_data_o (cpu_data_o),
    .bus_data_i (bus_data_i),
    .dma_active (dma_active),
    .cpu_halt   (cpu_halt),
    .dma_addr   (dma_addr),
    .dma_rw     (dma_rw),
    .dma_data_o (dma_data_o),
    .dma_done   (dma_done)
  );

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr [$];
  logic [7:0]  exp_data [$];

  int halt_cnt = 0;
  int pre_cnt  = 0;
  int done_cnt = 0;
  int exp_halt = 0;
  int exp_pre  = 0;
  bit gate     = 1'b0;
  logic tb_phase;

  wire [15:0] bus_addr = dma_active ? dma_addr : cpu_addr;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ce generator: every clk, or every third clk when gated.
  initial begin : ce_gen
    int g;
    g  = 0;
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (gate) begin
        g  = (g + 1) % 3;
        ce = (g == 0);
      end else begin
        ce = 1'b1;
      end
    end
  end

  // Bus memory: address presented in a clk, data valid after the next edge.
  initial begin : bus_model
    logic [15:0] a;
    bus_data_i = 8'h00;
    forever begin
      @(negedge clk);
      a = bus_addr;
      @(posedge clk);
      #1;
      bus_data_i = mem[a];
    end
  end

  // Reference free-running phase, restarted by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst)    tb_phase <= 1'b0;
    else if (ce) tb_phase <= ~tb_phase;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (dma_done) begin
        done_cnt++;
        vectors++;
        if (exp_addr.size() != 0 || exp_data.size() != 0) begin
          errors++;
          $display("FAIL done_early: reads left %0d writes left %0d, required 0/0",
                   exp_addr.size(), exp_data.size());
        end
      end
      if (dma_active && !dma_rw) begin
        vectors++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: addr %h data %h, none expected", dma_addr, dma_data_o);
        end else begin
          if (dma_addr !== 16'h2004 || dma_data_o !== exp_data[0]) begin
            errors++;
            $display("FAIL write: addr %h data %h, required addr 2004 data %h",
                     dma_addr, dma_data_o, exp_data[0]);
          end
          if (ce) void'(exp_data.pop_front());
        end
      end
      if (ce) begin
        if (cpu_halt)                halt_cnt++;
        if (cpu_halt && !dma_active) pre_cnt++;
        if (dma_active && dma_rw) begin
          vectors++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: addr %h, none expected", dma_addr);
          end else begin
            if (dma_addr !== exp_addr[0]) begin
              errors++;
              $display("FAIL read_addr: got %h, required %h", dma_addr, exp_addr[0]);
            end
            void'(exp_addr.pop_front());
          end
        end
      end
    end
  end

  // Issue a CPU write of page to $4014 so that HALT lands on halt_phase.
  task automatic trigger(input logic [7:0] page, input bit halt_phase);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ce && (tb_phase == !halt_phase)) && n < 20);
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back({page, i[7:0]});
      exp_data.push_back(mem_val({page, i[7:0]}));
    end
    exp_halt   = halt_phase ? 513 : 514;
    exp_pre    = halt_phase ? 1 : 2;
    halt_cnt   = 0;
    pre_cnt    = 0;
    done_cnt   = 0;
    cpu_addr   = 16'h4014;
    cpu_rw     = 1'b0;
    cpu_data_o = page;
    @(negedge clk);
    cpu_addr   = 16'h0000;
    cpu_rw     = 1'b1;
    cpu_data_o = 8'h00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!cpu_halt) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_read(input logic [15:0] a, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (ce && dma_active && dma_rw && dma_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dma_active, cpu_halt, dma_addr, dma_rw, dma_data_o, dma_done} !==
        {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: act %b halt %b addr %h rw %b data %h done %b, required 0 0 0000 1 00 0",
               dma_active, cpu_halt, dma_addr, dma_rw, dma_data_o, dma_done);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (cpu_halt !== 1'b0 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL idle: halt %b act %b, required 0 0", cpu_halt, dma_active);
    end
  endtask

  task automatic test_transfer(input string name, input logic [7:0] page, input bit hp);
    bit ok;
    trigger(page, hp);
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: transfer did not finish", name);
    end
    vectors++;
    if (halt_cnt != exp_halt) begin
      errors++;
      $display("FAIL %s_halt_cycles: got %0d, required %0d", name, halt_cnt, exp_halt);
    end
    vectors++;
    if (pre_cnt != exp_pre) begin
      errors++;
      $display("FAIL %s_align: pre-read halted cycles %0d, required %0d", name, pre_cnt, exp_pre);
    end
    vectors++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done: pulses %0d, required 1", name, done_cnt);
    end
    vectors++;
    if (exp_addr.size() != 0 || exp_data.size() != 0) begin
      errors++;
      $display("FAIL %s_count: reads left %0d writes left %0d, required 0/0",
               name, exp_addr.size(), exp_data.size());
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic test_retrigger();
    bit ok;
    trigger(8'h02, 1'b1);
    wait_read(16'h0220, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL retrig_reach: read of 0220 not seen");
    end
    cpu_addr   = 16'h4014;
    cpu_rw     = 1'b0;
    cpu_data_o = 8'h05;
    @(negedge clk);
    cpu_addr   = 16'h0000;
    cpu_rw     = 1'b1;
    cpu_data_o = 8'h00;
    wait_idle(ok);
    vectors++;
    if (!ok || exp_addr.size() != 0 || exp_data.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL retrig: ok %b reads left %0d writes left %0d done %0d, required 1 0 0 1",
               ok, exp_addr.size(), exp_data.size(), done_cnt);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (cpu_halt !== 1'b0) begin
      errors++;
      $display("FAIL retrig_restart: halt %b, required 0", cpu_halt);
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    trigger(8'h02, 1'b1);
    wait_read(16'h0240, ok);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_reach: read of 0240 not seen");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({dma_active, cpu_halt, dma_addr, dma_rw, dma_data_o, dma_done} !==
        {1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_outputs: act %b halt %b addr %h rw %b data %h done %b, required 0 0 0000 1 00 0",
               dma_active, cpu_halt, dma_addr, dma_rw, dma_data_o, dma_done);
    end
    exp_addr.delete();
    exp_data.delete();
    done_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (done_cnt != 0 || cpu_halt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: done pulses %0d halt %b, required 0 0", done_cnt, cpu_halt);
    end
    test_transfer("restart_p03", 8'h03, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    cpu_addr   = 16'h0000;
    cpu_rw     = 1'b1;
    cpu_data_o = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = mem_val(a[15:0]);

    test_reset();
    test_transfer("phase1", 8'h02, 1'b1);
    test_transfer("phase0", 8'h02, 1'b0);
    gate = 1'b1;
    repeat (6) @(negedge clk);
    test_transfer("gated", 8'h07, 1'b1);
    test_transfer("gated_p0", 8'h07, 1'b0);
    gate = 1'b0;
    repeat (6) @(negedge clk);
    test_transfer("page_ff", 8'hFF, 1'b1);
    test_retrigger();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
